// File: rtl/booth_recoder_pkg.sv
// Shared types and constants for the radix-4 Booth recoder slice.
package booth_pkg;

  localparam int OP_WIDTH        = 32;
  localparam int SR_WIDTH        = 35;
  localparam int IDX_WIDTH       = 5;
  localparam int GROUPS_SIGNED   = 16;
  localparam int GROUPS_UNSIGNED = 17;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  // Booth select flags for one radix-4 digit.
  typedef struct packed {
    logic zero;
    logic one;
    logic double;
    logic reverse;
  } sel_t;

  // Index of the final group for the chosen signedness.
  function automatic logic [IDX_WIDTH-1:0] last_group_idx(input logic is_unsigned);
    logic [IDX_WIDTH-1:0] idx_v;
    if (is_unsigned) begin
      idx_v = IDX_WIDTH'(GROUPS_UNSIGNED - 1);
    end else begin
      idx_v = IDX_WIDTH'(GROUPS_SIGNED - 1);
    end
    return idx_v;
  endfunction

  // Operand image {ext[1:0], multiplier, 0}; the low zero is bit -1 of group 0.
  function automatic logic [SR_WIDTH-1:0] load_operand(input logic [OP_WIDTH-1:0] m,
                                                       input logic is_unsigned);
    logic [1:0] ext_v;
    if (is_unsigned) begin
      ext_v = 2'b00;
    end else begin
      ext_v = {2{m[OP_WIDTH-1]}};
    end
    return {ext_v, m, 1'b0};
  endfunction

endpackage

// File: rtl/booth_recoder_if.sv
// Operand input and recoded-group output bundle of the Booth recoder.
interface booth_recoder_if;
  import booth_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [OP_WIDTH-1:0]  multiplier;
  logic                 in_unsigned;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic                 partial_zero;
  logic                 partial_one;
  logic                 partial_double;
  logic                 partial_reverse;
  logic [IDX_WIDTH-1:0] group_idx;
  logic                 group_first;
  logic                 group_last;

  // Operand producer / group consumer side.
  modport master (
    output in_valid, multiplier, in_unsigned, flush, out_ready,
    input  in_ready, out_valid, partial_zero, partial_one, partial_double,
           partial_reverse, group_idx, group_first, group_last
  );

  // Recoder side.
  modport slave (
    input  in_valid, multiplier, in_unsigned, flush, out_ready,
    output in_ready, out_valid, partial_zero, partial_one, partial_double,
           partial_reverse, group_idx, group_first, group_last
  );

endinterface

// File: rtl/booth_recoder_sel.sv
// Radix-4 Booth window decoder: (b2i+1, b2i, b2i-1) -> select flags.
module booth_sel
  import booth_pkg::*;
(
  input  logic [2:0] window,
  output sel_t       sel
);

  // Map the 3-bit window onto the digit in {-2,-1,0,+1,+2}.
  always_comb begin
    sel = '0;
    case (window)
      3'b000: sel.zero = 1'b1;
      3'b001,
      3'b010: sel.one = 1'b1;
      3'b011: sel.double = 1'b1;
      3'b100: begin
        sel.double  = 1'b1;
        sel.reverse = 1'b1;
      end
      3'b101,
      3'b110: begin
        sel.one     = 1'b1;
        sel.reverse = 1'b1;
      end
      3'b111: sel.zero = 1'b1;
      default: sel.zero = 1'b1;
    endcase
  end

endmodule

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoder: accepts a 32-bit multiplier and emits one select
// group per output handshake, least significant group first. Select flags,
// group_first and group_last are registered from the next-state values so
// the outputs come straight from flops.
module booth_recoder
  import booth_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  booth_recoder_if.slave bus
);

  state_e               state_r;
  state_e               state_nxt_s;
  logic [SR_WIDTH-1:0]  sh_r;
  logic [SR_WIDTH-1:0]  sh_nxt_s;
  logic [IDX_WIDTH-1:0] idx_r;
  logic [IDX_WIDTH-1:0] idx_nxt_s;
  logic                 uns_r;
  logic                 uns_nxt_s;
  sel_t                 sel_r;
  sel_t                 sel_dec_s;
  logic                 first_r;
  logic                 last_r;
  logic                 emit_nxt_s;
  logic                 out_hs_s;

  assign out_hs_s   = (state_r == ST_EMIT) && bus.out_ready;
  assign emit_nxt_s = (state_nxt_s == ST_EMIT);

  // Decode the window that will be current after this edge.
  booth_sel u_sel (
    .window (sh_nxt_s[2:0]),
    .sel    (sel_dec_s)
  );

  // Next-state, shift-register and group-counter logic.
  always_comb begin
    state_nxt_s = state_r;
    sh_nxt_s    = sh_r;
    idx_nxt_s   = idx_r;
    uns_nxt_s   = uns_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.flush) begin
          state_nxt_s = ST_IDLE;
        end else if (bus.in_valid) begin
          state_nxt_s = ST_EMIT;
          sh_nxt_s    = load_operand(bus.multiplier, bus.in_unsigned);
          idx_nxt_s   = 5'd0;
          uns_nxt_s   = bus.in_unsigned;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (bus.flush) begin
          state_nxt_s = ST_IDLE;
          sh_nxt_s    = '0;
          idx_nxt_s   = 5'd0;
        end else if (out_hs_s) begin
          if (idx_r == last_group_idx(uns_r)) begin
            state_nxt_s = ST_IDLE;
            sh_nxt_s    = '0;
            idx_nxt_s   = 5'd0;
          end else begin
            sh_nxt_s  = {2'b00, sh_r[SR_WIDTH-1:2]};
            idx_nxt_s = idx_r + 5'd1;
          end
        end else begin
          state_nxt_s = ST_EMIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        sh_nxt_s    = '0;
        idx_nxt_s   = 5'd0;
        uns_nxt_s   = 1'b0;
      end
    endcase
  end

  // State, operand and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      sh_r    <= '0;
      idx_r   <= 5'd0;
      uns_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      sh_r    <= sh_nxt_s;
      idx_r   <= idx_nxt_s;
      uns_r   <= uns_nxt_s;
    end
  end

  // Registered group flags; forced to zero whenever no group is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r   <= '0;
      first_r <= 1'b0;
      last_r  <= 1'b0;
    end else if (emit_nxt_s) begin
      sel_r   <= sel_dec_s;
      first_r <= (idx_nxt_s == 5'd0);
      last_r  <= (idx_nxt_s == last_group_idx(uns_nxt_s));
    end else begin
      sel_r   <= '0;
      first_r <= 1'b0;
      last_r  <= 1'b0;
    end
  end

  assign bus.in_ready        = (state_r == ST_IDLE);
  assign bus.out_valid       = (state_r == ST_EMIT);
  assign bus.partial_zero    = sel_r.zero;
  assign bus.partial_one     = sel_r.one;
  assign bus.partial_double  = sel_r.double;
  assign bus.partial_reverse = sel_r.reverse;
  assign bus.group_idx       = idx_r;
  assign bus.group_first     = first_r;
  assign bus.group_last      = last_r;

endmodule
